// File: rtl/register_file_16x16.sv
// 16 x 16-bit register file: two combinational read ports, one write port,
// R0 hardwired to zero, same-cycle write-through bypass on each read port.
module register_file_16x16 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        SrcReg1,
    input  logic [3:0]        SrcReg2,
    input  logic [3:0]        DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    logic [NREG-1:0]   wr_wl;
    logic [NREG-1:0]   rd1_wl;
    logic [NREG-1:0]   rd2_wl;
    logic [DATA_W-1:0] arr_rd1;
    logic [DATA_W-1:0] arr_rd2;
    logic              byp1;
    logic              byp2;
    logic              wr_live;

    // One-hot wordlines; bit 0 of the write wordline is never set so R0 stays zero
    always_comb begin
        wr_wl          = '0;
        rd1_wl         = '0;
        rd2_wl         = '0;
        wr_wl[DstReg]  = WriteReg;
        wr_wl[0]       = 1'b0;
        rd1_wl[SrcReg1] = 1'b1;
        rd2_wl[SrcReg2] = 1'b1;
    end

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (wr_wl[i]) begin
                regs_d[i] = DstData;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // AND-OR read muxes; entry 0 is excluded so R0 reads zero even before reset
    always_comb begin
        arr_rd1 = '0;
        arr_rd2 = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            arr_rd1 = arr_rd1 | ({DATA_W{rd1_wl[i]}} & regs_q[i]);
            arr_rd2 = arr_rd2 | ({DATA_W{rd2_wl[i]}} & regs_q[i]);
        end
    end

    // Bypass only for a live, non-R0 write in this cycle and never during reset
    always_comb begin
        wr_live  = !rst && WriteReg && (DstReg != 4'd0);
        byp1     = wr_live && (SrcReg1 == DstReg);
        byp2     = wr_live && (SrcReg2 == DstReg);
        SrcData1 = byp1 ? DstData : arr_rd1;
        SrcData2 = byp2 ? DstData : arr_rd2;
    end

endmodule

// File: doc/register_file_16x16.md
REGISTER_FILE_16X16 -- requirements
Module: register_file_16x16

Interface
REQ-001 Parameter DATA_W, default 16, width of each register and data port; only 16 is supported.
REQ-002 Parameter NREG, default 16, number of architectural registers; only 16 is supported.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SrcReg1  input  4  register ID for read port 1.
REQ-006 SrcReg2  input  4  register ID for read port 2.
REQ-007 DstReg  input  4  register ID for the write port.
REQ-008 WriteReg  input  1  write enable for the write port.
REQ-009 DstData  input  16  write data.
REQ-010 SrcData1  output  16  read data for port 1.
REQ-011 SrcData2  output  16  read data for port 2.

Function
REQ-012 The block SHALL hold 16 registers, R0..R15, each 16 bits wide.
REQ-013 Write selection SHALL use a one-hot write wordline decoded from DstReg and gated by WriteReg; a write SHALL never affect more than one register.
REQ-014 Read selection SHALL use two independent one-hot read wordlines decoded from SrcReg1 and SrcReg2.
REQ-015 At a clk rising edge with rst=0, WriteReg=1 and DstReg!=0, R[DstReg] SHALL load DstData.
REQ-016 R0 SHALL be hardwired to 0x0000; writes to R0 SHALL be ignored, and reads of R0 SHALL return 0x0000 on both ports.
REQ-017 Reads SHALL be combinational, with zero-cycle latency: SrcDataN = R[SrcRegN].
REQ-018 Write-through bypass: when rst=0, WriteReg=1, DstReg!=0 and SrcRegN==DstReg, SrcDataN SHALL equal DstData in the same cycle.
REQ-019 Bypass SHALL apply independently to each port, so both ports return DstData when both match DstReg.
REQ-020 When WriteReg=0, no register SHALL change and no bypass SHALL occur.
REQ-021 The register file SHALL support two reads and one write per cycle without stall or conflict, including SrcReg1==SrcReg2.
REQ-022 A write to Rk SHALL be visible through the array, without bypass, from the cycle after the write edge onward.
REQ-023 Bypass SHALL be driven only by the current-cycle write; stale or pending writes SHALL NOT affect read data.

Reset
REQ-024 At a clk rising edge with rst=1, all of R1..R15 SHALL become 0x0000.
REQ-025 Reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-026 While rst=1, bypass SHALL be disabled and SrcData1 and SrcData2 SHALL show the stored array contents.
REQ-027 After any reset edge, SrcData1 and SrcData2 SHALL read 0x0000 for every register ID until the next write.
REQ-028 Reset asserted in the middle of a write sequence SHALL leave no register holding a value written at or after the reset edge.
REQ-029 Before the first reset, register contents SHALL be undefined; the bench SHALL apply rst before checking any data.

Verification
REQ-030 Reset then read all IDs: rst=1 for 1 cycle, then sweep SrcReg1/SrcReg2 over 0..15 -> SrcData1 = SrcData2 = 0x0000 for every ID.
REQ-031 Write/readback: write Rk = 0x1000+k for k=1..15, then read each Rk -> port 1 and port 2 return 0x1000+k.
REQ-032 R0 protection: WriteReg=1, DstReg=0, DstData=0xFFFF, SrcReg1=0 -> SrcData1=0x0000 in the same cycle and in the next cycle.
REQ-033 Bypass: R5=0x1234 stored; WriteReg=1, DstReg=5, DstData=0xABCD, SrcReg1=SrcReg2=5 -> both ports read 0xABCD in the same cycle; R5 reads 0xABCD afterwards with WriteReg=0.
REQ-034 Reset vs write: R7=0x5555 stored; rst=1, WriteReg=1, DstReg=7, DstData=0x9999 -> R7 reads 0x0000 after the edge.
REQ-035 WriteReg gating: WriteReg=0, DstReg=3, DstData=0xBEEF -> R3 unchanged, no bypass on a port with SrcReg=3, all other registers unchanged.
